stream_fifo: RTL
================

// Module: stream_fifo
// PURPOSE
//  Parametrised synchronous FIFO with valid/ready handshakes on both sides and
//  first-word-fall-through (FWFT) read. Provides occupancy count, programmable
//  almost-full/almost-empty flags, a high-water mark and a synchronous flush.
//  Buffers operand/result streams between the tensor-core datapath and the
//  RISC-V load/store and command interfaces, all in the single clk domain.
// PARAMETERS
//  DATA_W   32  payload width in bits (>=1)
//  DEPTH    64  number of entries; power of two, >=2
//  AF_LVL   56  almost_full asserted when count >= AF_LVL (1..DEPTH)
//  AE_LVL   8   almost_empty asserted when count <= AE_LVL (0..DEPTH-1)
//  CNT_W = $clog2(DEPTH)+1 (localparam); ADDR_W = $clog2(DEPTH) (localparam)
// PORTS
//  clk           in   1       clock; all logic on rising edge
//  nrst          in   1       reset, asynchronous, active-low
//  flush         in   1       synchronous clear of contents, count and hwm
//  in_valid      in   1       producer has data on in_data
//  in_ready      out  1       FIFO accepts data this cycle
//  in_data       in   DATA_W  write payload
//  out_valid     out  1       out_data holds the head entry
//  out_ready     in   1       consumer takes head this cycle
//  out_data      out  DATA_W  head entry (FWFT); 0 when out_valid=0
//  count         out  CNT_W   current occupancy, 0..DEPTH
//  almost_full   out  1       count >= AF_LVL
//  almost_empty  out  1       count <= AE_LVL
//  hwm           out  CNT_W   highest count reached since reset/flush
// BEHAVIOUR
//  - Reset (nrst=0, async): wr_ptr=rd_ptr=0, count=0, hwm=0. Hence in_ready=1,
//    out_valid=0, out_data=0, almost_empty=1, almost_full=0. Memory not reset.
//  - push = in_valid & in_ready; pop = out_valid & out_ready.
//  - in_ready = (count != DEPTH); out_valid = (count != 0). Both combinational
//    from registered count only; no combinational path from in_valid/out_ready.
//  - push: mem[wr_ptr] <= in_data, wr_ptr += 1. pop: rd_ptr += 1.
//  - Pointers ADDR_W bits, wrap DEPTH-1 -> 0 naturally (power-of-two depth).
//  - count: +1 on push only, -1 on pop only, unchanged on both or neither.
//  - Simultaneous push+pop (0<count<DEPTH): both happen, count unchanged.
//  - Full: in_ready=0, push blocked even if pop same cycle (no pass-through);
//    pop proceeds, in_ready=1 next cycle.
//  - Empty: out_valid=0, write latency 1: data pushed in cycle N is on
//    out_data with out_valid=1 in cycle N+1. No bypass.
//  - out_data = mem[rd_ptr] when out_valid, else all zeros (no X leakage).
//  - hwm <= max(hwm, next_count) each cycle; saturates at DEPTH.
//  - flush=1: next edge wr_ptr=rd_ptr=count=hwm=0; overrides push/pop same
//    cycle (data offered that cycle is dropped, pop not counted).
//  - Reset mid-operation: all state cleared immediately, contents discarded.
//  - Holding in_valid with in_ready=0 is legal; in_data must stay stable.
// STRUCTURE
//  - fifo_pkg: localparam helpers (cnt/addr width function), fifo_level_t
//    typedef for shared occupancy reporting.
//  - Sub-module fifo_ram: DEPTH x DATA_W register array, 1 sync write port,
//    1 async read port. Pointer/count/flag/hwm control in stream_fifo top.
//  - Parameter legality checked by elaboration-time assertions.
// TESTING
//  1. Reset, no traffic -> in_ready=1, out_valid=0, out_data=0, count=0, ae=1.
//  2. Push 0x1..0x40 (DEPTH=64), no pop -> count=64, in_ready=0, af=1 at 56,
//     hwm=64; 65th push held off; then pop all -> data 0x1..0x40 in order.
//  3. Push 0xA5 into empty at cycle N -> out_valid=1, out_data=0xA5 at N+1.
//  4. count=10, push+pop every cycle for 200 cycles (ptr wrap) -> count=10
//     throughout, data order preserved, hwm=10.
//  5. Full, push+pop same cycle -> pop only, count=63, in_ready=1 next cycle.
//  6. count=20, flush with push+pop asserted -> count=0, hwm=0, out_valid=0;
//     nrst pulsed mid-stream -> same cleared state asynchronously.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared width helpers and occupancy-flag bundle for the stream FIFO family.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package fifo_pkg;

  // Pointer width for a power-of-two depth.
  function automatic int addr_width(input int depth);
    return $clog2(depth);
  endfunction

  // Occupancy width: one extra bit so a full FIFO (count == depth) is representable.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int depth);
    return (depth > 0) && ((depth & (depth - 1)) == 0);
  endfunction

  // Status flags derived from the registered occupancy.
  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_level_t;

endpackage

// File: rtl/fifo_ram.sv
// DEPTH x DATA_W register array, one synchronous write port, one async read port.
// Latency: write visible on the read port the cycle after the write edge.
// Backpressure: none; the caller gates the write enable.
module fifo_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage is deliberately not reset; count/pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/stream_fifo.sv
// Valid/ready FWFT FIFO with count, almost flags, high-water mark and sync flush.
// Latency: 1 cycle from push into an empty FIFO to out_valid; no bypass path.
// Backpressure: in_ready drops only at count == DEPTH; no pass-through when full.
module stream_fifo
  import fifo_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 64,
  parameter  int AF_LVL = 56,
  parameter  int AE_LVL = 8,
  localparam int CNT_W  = cnt_width(DEPTH),
  localparam int ADDR_W = addr_width(DEPTH)
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  count,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [CNT_W-1:0]  hwm
);

  if (DATA_W < 1) begin : g_bad_data_w
    $error("stream_fifo: DATA_W must be >= 1");
  end
  if (DEPTH < 2 || !is_pow2(DEPTH)) begin : g_bad_depth
    $error("stream_fifo: DEPTH must be a power of two >= 2");
  end
  if (AF_LVL < 1 || AF_LVL > DEPTH) begin : g_bad_af
    $error("stream_fifo: AF_LVL must be in 1..DEPTH");
  end
  if (AE_LVL < 0 || AE_LVL > DEPTH - 1) begin : g_bad_ae
    $error("stream_fifo: AE_LVL must be in 0..DEPTH-1");
  end

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_nxt;
  logic [CNT_W-1:0]  hwm_q;
  logic [CNT_W-1:0]  hwm_nxt;
  logic [DATA_W-1:0] rdata;
  logic              push;
  logic              pop;
  fifo_level_t       level;

  // Flags depend only on registered count, keeping ready/valid free of input paths.
  always_comb begin
    level              = '0;
    level.full         = (count_q == CNT_W'(DEPTH));
    level.empty        = (count_q == '0);
    level.almost_full  = (count_q >= CNT_W'(AF_LVL));
    level.almost_empty = (count_q <= CNT_W'(AE_LVL));
  end

  assign in_ready     = ~level.full;
  assign out_valid    = ~level.empty;
  assign almost_full  = level.almost_full;
  assign almost_empty = level.almost_empty;
  assign count        = count_q;
  assign hwm          = hwm_q;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // Next occupancy and high-water mark; flush wins over any same-cycle push/pop.
  always_comb begin
    count_nxt = count_q;
    hwm_nxt   = hwm_q;
    if (flush) begin
      count_nxt = '0;
      hwm_nxt   = '0;
    end else begin
      if (push && !pop) begin
        count_nxt = count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_nxt = count_q - CNT_W'(1);
      end
      // count_nxt never exceeds DEPTH, so the mark saturates there naturally.
      if (count_nxt > hwm_q) begin
        hwm_nxt = count_nxt;
      end
    end
  end

  // Pointer, count and high-water registers; async clear on reset.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      hwm_q   <= '0;
    end else begin
      count_q <= count_nxt;
      hwm_q   <= hwm_nxt;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + ADDR_W'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + ADDR_W'(1);
        end
      end
    end
  end

  fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (push & ~flush),
    .waddr (wr_ptr),
    .wdata (in_data),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  // Head entry only when valid, so stale or uninitialised storage never leaks out.
  assign out_data = out_valid ? rdata : '0;

endmodule
